uart_wb_sequencer: RTL and testbench
====================================

UART_WB_SEQUENCER -- requirements
Module: uart_wb_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, max cycles a Wishbone access may wait for ack before abort (range 1..255).
REQ-002 SHALL have parameter FCR_VAL, default 8'hC7, value written to FCR during init.
REQ-003 SHALL use a single clock and a synchronous, active-high reset; all state changes on rising edge of clk_i.
REQ-004 clk_i  input  1  system clock; also drives the Wishbone master side.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 cfg_start_i  input  1  one-cycle pulse, start (re)initialisation of the UART.
REQ-007 cfg_divisor_i  input  16  baud divisor, sampled on accepted cfg_start_i.
REQ-008 cfg_lcr_i  input  8  line format, sampled on accepted cfg_start_i; bit 7 ignored.
REQ-009 init_done_o  output  1  high while UART is configured and no error.
REQ-010 busy_o  output  1  high whenever a Wishbone cycle or pending byte is in progress.
REQ-011 err_o  output  1  sticky ack-timeout flag.
REQ-012 tx_data_i  input  8  byte to transmit; tx_valid_i  input  1; tx_ready_o  output  1 (valid/ready stream).
REQ-013 wb_adr_o 3, wb_dat_o 8, wb_we_o 1, wb_stb_o 1, wb_cyc_o 1 outputs; wb_dat_i 8, wb_ack_i 1 inputs; Wishbone classic master to 16550-compatible UART.

Function
REQ-014 States: IDLE, CFG, READY, POLL, WRTHR, ERR; one Wishbone access engine shared by CFG, POLL, WRTHR.
REQ-015 Access: cyc/stb/adr/dat/we asserted registered and held constant until the cycle wb_ack_i sampled high; cyc/stb low the next cycle; minimum one idle cycle between accesses.
REQ-016 In IDLE or READY, cfg_start_i high -> capture divisor/lcr, enter CFG, clear err_o and init_done_o; cfg_start_i ignored in CFG, POLL, WRTHR.
REQ-017 In ERR, cfg_start_i high -> same as REQ-016 (recovery path).
REQ-018 CFG SHALL issue exactly six writes in order: adr 3 <= {1'b1,lcr[6:0]}; adr 0 <= div[7:0]; adr 1 <= div[15:8]; adr 3 <= {1'b0,lcr[6:0]}; adr 2 <= FCR_VAL; adr 1 <= 8'h00; then READY with init_done_o=1.
REQ-019 tx_ready_o = (state==READY) && !cfg_start_i (combinational); cfg_start_i wins over a simultaneous tx_valid_i.
REQ-020 Byte accepted on tx_valid_i && tx_ready_o: latch tx_data_i, enter POLL.
REQ-021 POLL: read adr 5 (we=0); on ack, if wb_dat_i[5]==1 -> WRTHR, else repeat read after the idle cycle.
REQ-022 WRTHR: write adr 0 <= latched byte; on ack -> READY.
REQ-023 Timeout: 8-bit counter cleared at start of each access, increments each cycle stb high without ack; reaching ACK_TIMEOUT with no ack -> drop cyc/stb next cycle, enter ERR, err_o=1, init_done_o=0, pending byte discarded.
REQ-024 ack arriving in the same cycle the counter reaches ACK_TIMEOUT counts as success.
REQ-025 wb_ack_i while cyc low SHALL be ignored.
REQ-026 busy_o = state in {CFG, POLL, WRTHR}.

Reset
REQ-027 On rst_i: state IDLE; wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_adr_o=0; wb_dat_o=0; init_done_o=0; err_o=0; busy_o=0; tx_ready_o=0; counters and latches cleared.
REQ-028 rst_i mid-access SHALL drop cyc/stb in the following cycle with no further access; outstanding byte lost.

Verification
REQ-029 Reset, cfg_start_i with div=16'h0036, lcr=8'h03, slave acks after 1 cycle -> writes (3,83),(0,36),(1,00),(3,03),(2,C7),(1,00) in order, then init_done_o=1.
REQ-030 After init, send 8'h41 with LSR returning 8'h00 twice then 8'h60 -> three reads of adr 5, one write (0,41), tx_ready_o low throughout, high again after.
REQ-031 Slave never acks during CFG step 2, ACK_TIMEOUT=255 -> cyc/stb drop after 255 stb cycles, err_o=1, init_done_o=0; subsequent cfg_start_i clears err_o and reruns all six writes.
REQ-032 In READY, assert cfg_start_i and tx_valid_i same cycle -> byte not accepted (tx_ready_o=0), CFG sequence starts.
REQ-033 Assert rst_i during POLL read with stb high -> next cycle cyc/stb=0, all outputs at reset values, no THR write occurs.
REQ-034 Ack on exactly cycle 255 of a POLL read -> access succeeds, no ERR.

Source files
------------

// File: rtl/uart_wb_sequencer.sv
// Wishbone classic master that initialises a 16550-compatible UART and then
// pushes bytes from a valid/ready stream into its THR, polling LSR.THRE first.
module uart_wb_sequencer #(
  parameter int         ACK_TIMEOUT = 255,
  parameter logic [7:0] FCR_VAL     = 8'hC7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_start_i,
  input  logic [15:0] cfg_divisor_i,
  input  logic [7:0]  cfg_lcr_i,
  output logic        init_done_o,
  output logic        busy_o,
  output logic        err_o,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [2:0]  wb_adr_o,
  output logic [7:0]  wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_READY, S_POLL, S_WRTHR, S_ERR
  } state_t;

  // Last stb cycle that may still be acked; an unacked stb in this cycle aborts.
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      r_state, w_next;
  logic        r_cyc, r_stb, r_we;
  logic [2:0]  r_adr;
  logic [7:0]  r_dat;
  logic [7:0]  r_cnt;
  logic [2:0]  r_step;
  logic [15:0] r_div;
  logic [6:0]  r_lcr;
  logic [7:0]  r_byte;
  logic        r_init, r_err;

  logic        w_start, w_accept, w_ack, w_timeout, w_busy, w_tx_ready;
  logic [2:0]  w_adr;
  logic [7:0]  w_dat;
  logic        w_we;
  logic        w_unused;

  // Only LSR.THRE matters; LCR bit 7 is driven by the sequencer itself.
  assign w_unused   = ^{wb_dat_i[7:6], wb_dat_i[4:0], cfg_lcr_i[7]};

  assign w_busy     = (r_state == S_CFG) || (r_state == S_POLL) || (r_state == S_WRTHR);
  assign w_tx_ready = (r_state == S_READY) && !cfg_start_i;
  assign w_start    = cfg_start_i &&
                      ((r_state == S_IDLE) || (r_state == S_READY) || (r_state == S_ERR));
  assign w_accept   = tx_valid_i && w_tx_ready;
  // Acks outside an active cycle are ignored.
  assign w_ack      = r_cyc && wb_ack_i;
  assign w_timeout  = r_cyc && !wb_ack_i && (r_cnt == TO_LAST);

  assign init_done_o = r_init;
  assign err_o       = r_err;
  assign busy_o      = w_busy;
  assign tx_ready_o  = w_tx_ready;
  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_stb;
  assign wb_we_o     = r_we;
  assign wb_adr_o    = r_adr;
  assign wb_dat_o    = r_dat;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a timeout in any access-issuing state lands in ERR.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_CFG;
      S_READY: begin
        if (w_start)       w_next = S_CFG;
        else if (w_accept) w_next = S_POLL;
      end
      S_ERR:   if (w_start) w_next = S_CFG;
      S_CFG: begin
        if (w_timeout)                    w_next = S_ERR;
        else if (w_ack && r_step == 3'd5) w_next = S_READY;
      end
      S_POLL: begin
        if (w_timeout)                w_next = S_ERR;
        else if (w_ack && wb_dat_i[5]) w_next = S_WRTHR;
      end
      S_WRTHR: begin
        if (w_timeout)  w_next = S_ERR;
        else if (w_ack) w_next = S_READY;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address/data/direction of the access the current state wants to issue.
  always_comb begin
    w_adr = 3'd0;
    w_dat = 8'h00;
    w_we  = 1'b0;
    case (r_state)
      S_CFG: begin
        w_we = 1'b1;
        case (r_step)
          3'd0: begin w_adr = 3'd3; w_dat = {1'b1, r_lcr}; end
          3'd1: begin w_adr = 3'd0; w_dat = r_div[7:0];    end
          3'd2: begin w_adr = 3'd1; w_dat = r_div[15:8];   end
          3'd3: begin w_adr = 3'd3; w_dat = {1'b0, r_lcr}; end
          3'd4: begin w_adr = 3'd2; w_dat = FCR_VAL;       end
          default: begin w_adr = 3'd1; w_dat = 8'h00;      end
        endcase
      end
      S_POLL:  begin w_adr = 3'd5; w_dat = 8'h00; w_we = 1'b0; end
      S_WRTHR: begin w_adr = 3'd0; w_dat = r_byte; w_we = 1'b1; end
      default: ;
    endcase
  end

  // Access engine: issue from idle bus, hold until ack or timeout, then drop for one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cyc <= 1'b0;
      r_stb <= 1'b0;
      r_we  <= 1'b0;
      r_adr <= 3'd0;
      r_dat <= 8'h00;
      r_cnt <= 8'd0;
    end else if (r_cyc) begin
      if (w_ack || w_timeout) begin
        r_cyc <= 1'b0;
        r_stb <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end else if (w_busy) begin
      r_cyc <= 1'b1;
      r_stb <= 1'b1;
      r_we  <= w_we;
      r_adr <= w_adr;
      r_dat <= w_dat;
      r_cnt <= 8'd0;
    end
  end

  // Configuration capture, sequence step, pending byte and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_step <= 3'd0;
      r_div  <= 16'h0000;
      r_lcr  <= 7'h00;
      r_byte <= 8'h00;
      r_init <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_div  <= cfg_divisor_i;
        r_lcr  <= cfg_lcr_i[6:0];
        r_step <= 3'd0;
        r_init <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_accept) r_byte <= tx_data_i;
      if (r_state == S_CFG && w_ack) begin
        r_step <= r_step + 3'd1;
        if (r_step == 3'd5) r_init <= 1'b1;
      end
      if (w_timeout) begin
        r_err  <= 1'b1;
        r_init <= 1'b0;
        r_byte <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_uart_wb_sequencer.sv
// Directed bench for uart_wb_sequencer with a behavioural Wishbone UART slave.
module tb_uart_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        cfg_start_i = 1'b0;
  logic [15:0] cfg_divisor_i = 16'h0000;
  logic [7:0]  cfg_lcr_i = 8'h00;
  logic        init_done_o, busy_o, err_o;
  logic [7:0]  tx_data_i = 8'h00;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [2:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [7:0]  wb_dat_i;
  logic        wb_ack_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Slave model controls
  int   ack_delay  = 1;
  int   nack_at    = -1;
  logic force_ack  = 1'b0;
  int   lsr_zero_n = 0;
  int   rd_base    = 0;

  // Slave model state
  int   tb_wait    = 0;
  int   tb_lastlen = 0;
  int   log_n      = 0;
  int   rd_cnt     = 0;
  logic [2:0] log_adr [0:255];
  logic [7:0] log_dat [0:255];
  logic       log_we  [0:255];

  always #5 clk = ~clk;

  uart_wb_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_start_i(cfg_start_i),
    .cfg_divisor_i(cfg_divisor_i), .cfg_lcr_i(cfg_lcr_i),
    .init_done_o(init_done_o), .busy_o(busy_o), .err_o(err_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  // Ack in stb cycle number ack_delay+1; the access numbered nack_at is never acked.
  assign wb_ack_i = force_ack |
                    (wb_cyc_o && wb_stb_o && (log_n != nack_at) && (tb_wait == ack_delay));
  // LSR: THRE clear for the first lsr_zero_n reads since rd_base, then 8'h60.
  assign wb_dat_i = ((rd_cnt - rd_base) < lsr_zero_n) ? 8'h00 : 8'h60;

  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o) tb_wait <= tb_wait + 1;
    else begin
      if (tb_wait != 0) tb_lastlen <= tb_wait;
      tb_wait <= 0;
    end
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      log_adr[log_n[7:0]] <= wb_adr_o;
      log_dat[log_n[7:0]] <= wb_dat_o;
      log_we[log_n[7:0]]  <= wb_we_o;
      log_n <= log_n + 1;
      if (!wb_we_o) rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic pulse_start(input logic [15:0] div, input logic [7:0] lcr);
    @(negedge clk);
    cfg_start_i   = 1'b1;
    cfg_divisor_i = div;
    cfg_lcr_i     = lcr;
    @(negedge clk);
    cfg_start_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000)
      $display("FAIL reset_bus_ctl: got %b expected 000", {wb_cyc_o, wb_stb_o, wb_we_o});
    else n_pass++;
    n_checks++;
    if ({wb_adr_o, wb_dat_o} !== 11'h000)
      $display("FAIL reset_bus_adr_dat: got %h/%h expected 0/00", wb_adr_o, wb_dat_o);
    else n_pass++;
    n_checks++;
    if ({init_done_o, err_o, busy_o, tx_ready_o} !== 4'b0000)
      $display("FAIL reset_status: got %b expected 0000", {init_done_o, err_o, busy_o, tx_ready_o});
    else n_pass++;
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy_o, tx_ready_o, wb_cyc_o} !== 3'b000)
      $display("FAIL idle_after_reset: got %b expected 000", {busy_o, tx_ready_o, wb_cyc_o});
    else n_pass++;
  endtask

  task automatic test_init();
    logic [10:0] exp [6];
    int base;
    bit ok;
    exp = '{{3'd3, 8'h83}, {3'd0, 8'h36}, {3'd1, 8'h00},
            {3'd3, 8'h03}, {3'd2, 8'hC7}, {3'd1, 8'h00}};
    base = log_n;
    ok = 0;
    pulse_start(16'h0036, 8'h03);
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL init_busy: got %b expected 1", busy_o);
    else n_pass++;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (init_done_o) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) $display("FAIL init_done_timeout: got 0 expected init_done_o=1 within 200 cycles");
    else n_pass++;
    n_checks++;
    if (log_n - base !== 6) $display("FAIL init_count: got %0d expected 6", log_n - base);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({log_we[base + i], log_adr[base + i], log_dat[base + i]} !== {1'b1, exp[i]})
        $display("FAIL init_write%0d: got we=%b adr=%h dat=%h expected we=1 adr=%h dat=%h",
                 i, log_we[base + i], log_adr[base + i], log_dat[base + i], exp[i][10:8], exp[i][7:0]);
      else n_pass++;
    end
    n_checks++;
    if ({tx_ready_o, busy_o, err_o} !== 3'b100)
      $display("FAIL init_ready: got %b expected 100", {tx_ready_o, busy_o, err_o});
    else n_pass++;
  endtask

  task automatic test_tx();
    int base;
    bit ok;
    bit low_seen_high;
    base = log_n;
    rd_base = rd_cnt;
    lsr_zero_n = 2;
    ok = 0;
    low_seen_high = 0;
    @(negedge clk);
    n_checks++;
    if (tx_ready_o !== 1'b1) $display("FAIL tx_ready_before: got %b expected 1", tx_ready_o);
    else n_pass++;
    tx_data_i = 8'h41;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    n_checks++;
    if ({tx_ready_o, busy_o} !== 2'b01)
      $display("FAIL tx_accept: got ready/busy=%b expected 01", {tx_ready_o, busy_o});
    else n_pass++;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_ready_o) begin ok = 1; break; end
      if (!busy_o) low_seen_high = 1;
    end
    n_checks++;
    if (!ok || low_seen_high)
      $display("FAIL tx_complete: got ok=%b idle_gap=%b expected ok=1 idle_gap=0", ok, low_seen_high);
    else n_pass++;
    n_checks++;
    if (log_n - base !== 4) $display("FAIL tx_count: got %0d expected 4", log_n - base);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({log_we[base + i], log_adr[base + i]} !== 4'b0101)
        $display("FAIL tx_poll%0d: got we=%b adr=%h expected we=0 adr=5",
                 i, log_we[base + i], log_adr[base + i]);
      else n_pass++;
    end
    n_checks++;
    if ({log_we[base + 3], log_adr[base + 3], log_dat[base + 3]} !== {1'b1, 3'd0, 8'h41})
      $display("FAIL tx_thr: got we=%b adr=%h dat=%h expected we=1 adr=0 dat=41",
               log_we[base + 3], log_adr[base + 3], log_dat[base + 3]);
    else n_pass++;
  endtask

  task automatic test_start_vs_tx();
    int base;
    bit ok;
    base = log_n;
    ok = 0;
    @(negedge clk);
    cfg_start_i = 1'b1;
    cfg_divisor_i = 16'h1234;
    cfg_lcr_i = 8'h1B;
    tx_data_i = 8'h55;
    tx_valid_i = 1'b1;
    #1;
    n_checks++;
    if (tx_ready_o !== 1'b0) $display("FAIL start_wins_ready: got %b expected 0", tx_ready_o);
    else n_pass++;
    @(negedge clk);
    cfg_start_i = 1'b0;
    tx_valid_i = 1'b0;
    n_checks++;
    if ({busy_o, init_done_o} !== 2'b10)
      $display("FAIL start_wins_state: got busy/init=%b expected 10", {busy_o, init_done_o});
    else n_pass++;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (init_done_o) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok || (log_n - base) !== 6)
      $display("FAIL start_wins_count: got ok=%b writes=%0d expected ok=1 writes=6", ok, log_n - base);
    else n_pass++;
    n_checks++;
    if ({log_adr[base], log_dat[base], log_adr[base + 1], log_dat[base + 1], log_dat[base + 2]}
        !== {3'd3, 8'h9B, 3'd0, 8'h34, 8'h12})
      $display("FAIL start_wins_seq: got %h:%h %h:%h %h expected 3:9b 0:34 12",
               log_adr[base], log_dat[base], log_adr[base + 1], log_dat[base + 1], log_dat[base + 2]);
    else n_pass++;
  endtask

  task automatic test_ack_ignored();
    @(negedge clk);
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({err_o, tx_ready_o, wb_cyc_o, busy_o, init_done_o} !== 5'b01001)
      $display("FAIL stray_ack: got %b expected 01001",
               {err_o, tx_ready_o, wb_cyc_o, busy_o, init_done_o});
    else n_pass++;
  endtask

  task automatic test_ack_255();
    int base;
    bit ok;
    base = log_n;
    ok = 0;
    ack_delay = 254;
    rd_base = rd_cnt;
    lsr_zero_n = 0;
    @(negedge clk);
    tx_data_i = 8'h5A;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_ready_o || err_o) begin ok = tx_ready_o; break; end
    end
    repeat (2) @(negedge clk);
    ack_delay = 1;
    n_checks++;
    if (!ok || {err_o, init_done_o} !== 2'b01)
      $display("FAIL ack255_status: got ok=%b err=%b init=%b expected ok=1 err=0 init=1",
               ok, err_o, init_done_o);
    else n_pass++;
    n_checks++;
    if (tb_lastlen !== 255) $display("FAIL ack255_len: got %0d expected 255", tb_lastlen);
    else n_pass++;
    n_checks++;
    if ((log_n - base) !== 2 || {log_we[base], log_adr[base]} !== 4'b0101 ||
        {log_we[base + 1], log_adr[base + 1], log_dat[base + 1]} !== {1'b1, 3'd0, 8'h5A})
      $display("FAIL ack255_seq: got n=%0d last we=%b adr=%h dat=%h expected n=2 we=1 adr=0 dat=5a",
               log_n - base, log_we[base + 1], log_adr[base + 1], log_dat[base + 1]);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [10:0] exp [6];
    int base;
    bit ok;
    exp = '{{3'd3, 8'h83}, {3'd0, 8'h36}, {3'd1, 8'h00},
            {3'd3, 8'h03}, {3'd2, 8'hC7}, {3'd1, 8'h00}};
    base = log_n;
    nack_at = log_n + 1;
    ok = 0;
    pulse_start(16'h0036, 8'h03);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (err_o) begin ok = 1; break; end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (!ok) $display("FAIL timeout_err: got err_o=0 expected 1 within 600 cycles");
    else n_pass++;
    n_checks++;
    if ({err_o, init_done_o, wb_cyc_o, wb_stb_o, busy_o, tx_ready_o} !== 6'b100000)
      $display("FAIL timeout_state: got %b expected 100000",
               {err_o, init_done_o, wb_cyc_o, wb_stb_o, busy_o, tx_ready_o});
    else n_pass++;
    n_checks++;
    if (tb_lastlen !== 255) $display("FAIL timeout_len: got %0d expected 255", tb_lastlen);
    else n_pass++;
    n_checks++;
    if ((log_n - base) !== 1) $display("FAIL timeout_count: got %0d expected 1", log_n - base);
    else n_pass++;
    nack_at = -1;
    base = log_n;
    ok = 0;
    pulse_start(16'h0036, 8'h03);
    n_checks++;
    if ({err_o, busy_o} !== 2'b01) $display("FAIL recover_clear: got err/busy=%b expected 01", {err_o, busy_o});
    else n_pass++;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (init_done_o) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok || (log_n - base) !== 6)
      $display("FAIL recover_count: got ok=%b writes=%0d expected ok=1 writes=6", ok, log_n - base);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({log_we[base + i], log_adr[base + i], log_dat[base + i]} !== {1'b1, exp[i]})
        $display("FAIL recover_write%0d: got we=%b adr=%h dat=%h expected we=1 adr=%h dat=%h",
                 i, log_we[base + i], log_adr[base + i], log_dat[base + i], exp[i][10:8], exp[i][7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_poll();
    int base;
    bit ok;
    bit wr_seen;
    ack_delay = 3;
    rd_base = rd_cnt;
    lsr_zero_n = 1000;
    base = log_n;
    ok = 0;
    wr_seen = 0;
    @(negedge clk);
    tx_data_i = 8'h77;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wb_stb_o && wb_adr_o == 3'd5 && !wb_we_o) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) $display("FAIL rst_poll_seen: got no POLL read expected one within 50 cycles");
    else n_pass++;
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o} !== 14'h0000)
      $display("FAIL rst_poll_bus: got cyc=%b stb=%b we=%b adr=%h dat=%h expected all 0",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o);
    else n_pass++;
    n_checks++;
    if ({init_done_o, err_o, busy_o, tx_ready_o} !== 4'b0000)
      $display("FAIL rst_poll_status: got %b expected 0000", {init_done_o, err_o, busy_o, tx_ready_o});
    else n_pass++;
    repeat (20) @(negedge clk);
    for (int i = base; i < log_n; i++) if (log_we[i]) wr_seen = 1;
    n_checks++;
    if (wr_seen || wb_cyc_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL rst_poll_no_thr: got write=%b cyc=%b busy=%b expected 0 0 0", wr_seen, wb_cyc_o, busy_o);
    else n_pass++;
    ack_delay = 1;
  endtask

  initial begin
    test_reset();
    test_init();
    test_tx();
    test_start_vs_tx();
    test_ack_ignored();
    test_ack_255();
    test_timeout();
    test_reset_mid_poll();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
